pc_nzp: RTL and testbench
=========================

// Module: pc_nzp
// PURPOSE
// - Per-thread program-counter and NZP condition-flag unit of the mini-GPU core datapath.
// - Holds the 3-bit NZP flag register. In the EXECUTE core state it computes the
//   registered next PC: sequential (pc+1) or branch target (immediate).
// - The NZP register is written from the ALU compare result in the UPDATE core state.
// PARAMETERS
// - PC_WIDTH       8  width of current_pc, immediate, next_pc
// - NZP_WIDTH      3  flag width, fixed at 3 (bit2=N, bit1=Z, bit0=P)
// - STATE_WIDTH    3  width of core_state encoding
// PORTS
// - clock             in   1          system clock; all state changes on rising edge
// - reset             in   1          synchronous, active-high reset
// - enable            in   1          thread active; when low, all registers hold
// - core_state        in   3          core FSM state; 3'b101=EXECUTE, 3'b110=UPDATE
// - pc_out_mux        in   1          1 = branch instruction (BRnzp), 0 = sequential
// - nzp_instr         in   3          branch condition mask from the decoded instruction
// - nzp_out           in   3          new flag value from the ALU compare
// - current_pc        in   PC_WIDTH   PC of the instruction being executed
// - immediate         in   PC_WIDTH   branch target address
// - nzp_write_enable  in   1          instruction updates NZP (CMP)
// - nzp               out  3          registered NZP flags
// - next_pc           out  PC_WIDTH   registered next program counter
// BEHAVIOUR
// - Reset (sync, reset=1 at posedge):
//   - next_pc <= 0, nzp <= 3'b000.
//   - Reset dominates enable and core_state.
// - enable=0 (no reset): next_pc and nzp hold their values.
// - EXECUTE (core_state==3'b101, enable=1):
//   - If pc_out_mux==1 and (nzp & nzp_instr)!=0: next_pc <= immediate.
//   - Otherwise: next_pc <= current_pc + 1, truncated to PC_WIDTH (255+1 wraps to 0).
//   - The branch test uses the nzp register value before this edge.
//   - nzp_instr==000 never branches.
//   - nzp_instr==111 branches iff any flag is set.
//   - nzp is unchanged in EXECUTE, even if nzp_write_enable=1.
// - UPDATE (core_state==3'b110, enable=1):
//   - If nzp_write_enable==1: nzp <= nzp_out; otherwise nzp holds.
//   - next_pc is unchanged in UPDATE.
// - All other core_state values: both registers hold.
// - Latency: one clock. Outputs reflect the inputs sampled at the preceding rising edge.
// - Both outputs come straight from flops; there is no combinational input-to-output path.
// - nzp_out is stored as given; no one-hot check is applied.
// - Reset mid-operation clears both registers at that edge. The next EXECUTE uses nzp=000.
// STRUCTURE
// - Shared package (core_pkg):
//   - core-state localparams: IDLE, FETCH, DECODE, REQUEST, WAIT, EXECUTE=3'b101, UPDATE=3'b110, DONE.
//   - NZP bit-index constants.
// - Single module, no sub-modules. Logic is one sequential always block plus a combinational branch-taken term.
// TESTING
// - Reset: reset=1 for one edge -> next_pc==0, nzp==000.
// - NZP write: nzp_out=010, nzp_write_enable=1, core_state=110, one edge -> nzp==010.
// - Branch taken: nzp=010, state=101, pc_out_mux=1, nzp_instr=010, immediate=100, current_pc=10,
//   one edge -> next_pc==100.
// - Branch not taken: same, but nzp_instr=001 -> next_pc==11.
// - Sequential and wrap: pc_out_mux=0, current_pc=255, state=101 -> next_pc==0.
//   With enable=0 -> next_pc and nzp unchanged.
// - Write gating: nzp_write_enable=1 during state=101, or state=110 with enable=0 -> nzp unchanged.

Source files
------------

// File: rtl/core_pkg.sv
// Core-wide constants shared by the mini-GPU datapath: core FSM state codes
// and the bit positions of the N/Z/P flags.
package core_pkg;

    localparam logic [2:0] IDLE    = 3'b000;
    localparam logic [2:0] FETCH   = 3'b001;
    localparam logic [2:0] DECODE  = 3'b010;
    localparam logic [2:0] REQUEST = 3'b011;
    localparam logic [2:0] WAIT    = 3'b100;
    localparam logic [2:0] EXECUTE = 3'b101;
    localparam logic [2:0] UPDATE  = 3'b110;
    localparam logic [2:0] DONE    = 3'b111;

    localparam int unsigned NZP_N = 2;
    localparam int unsigned NZP_Z = 1;
    localparam int unsigned NZP_P = 0;

endpackage

// File: rtl/pc_nzp.sv
// Per-thread program-counter and NZP flag unit: registers the next PC in
// EXECUTE and the ALU compare flags in UPDATE.
module pc_nzp
    import core_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = 8,
    parameter int unsigned NZP_WIDTH   = 3,
    parameter int unsigned STATE_WIDTH = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [STATE_WIDTH-1:0] core_state,
    input  logic                   pc_out_mux,
    input  logic [NZP_WIDTH-1:0]   nzp_instr,
    input  logic [NZP_WIDTH-1:0]   nzp_out,
    input  logic [PC_WIDTH-1:0]    current_pc,
    input  logic [PC_WIDTH-1:0]    immediate,
    input  logic                   nzp_write_enable,
    output logic [NZP_WIDTH-1:0]   nzp,
    output logic [PC_WIDTH-1:0]    next_pc
);

    logic branch_taken;

    // Branch decision uses the flags registered before this edge.
    always_comb begin
        branch_taken = pc_out_mux &&
                       ((nzp[NZP_N] && nzp_instr[NZP_N]) ||
                        (nzp[NZP_Z] && nzp_instr[NZP_Z]) ||
                        (nzp[NZP_P] && nzp_instr[NZP_P]));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            next_pc <= '0;
            nzp     <= '0;
        end else if (enable) begin
            if (core_state == EXECUTE) begin
                if (branch_taken) begin
                    next_pc <= immediate;
                end else begin
                    next_pc <= current_pc + PC_WIDTH'(1);
                end
            end else if (core_state == UPDATE) begin
                if (nzp_write_enable) begin
                    nzp <= nzp_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_nzp.sv
// Directed self-checking bench for pc_nzp with hand-computed expectations.
module tb_pc_nzp;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] core_state;
    logic       pc_out_mux;
    logic [2:0] nzp_instr;
    logic [2:0] nzp_out;
    logic [7:0] current_pc;
    logic [7:0] immediate;
    logic       nzp_write_enable;
    logic [2:0] nzp;
    logic [7:0] next_pc;

    int checks = 0;
    int errors = 0;

    pc_nzp #(.PC_WIDTH(8), .NZP_WIDTH(3), .STATE_WIDTH(3)) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .core_state(core_state),
        .pc_out_mux(pc_out_mux),
        .nzp_instr(nzp_instr),
        .nzp_out(nzp_out),
        .current_pc(current_pc),
        .immediate(immediate),
        .nzp_write_enable(nzp_write_enable),
        .nzp(nzp),
        .next_pc(next_pc)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_both(input string tag, input logic [7:0] exp_pc, input logic [2:0] exp_nzp);
        check({tag, "_pc"}, next_pc, exp_pc);
        check({tag, "_nzp"}, {5'b0, nzp}, {5'b0, exp_nzp});
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; core_state = 3'b000; pc_out_mux = 1'b0;
        nzp_instr = 3'b000; nzp_out = 3'b000; current_pc = 8'd0; immediate = 8'd0;
        nzp_write_enable = 1'b0;
        @(negedge clock);
        tick();
        check_both("reset", 8'd0, 3'b000);
        reset = 1'b0;

        // NZP write in UPDATE
        core_state = 3'b110; nzp_out = 3'b010; nzp_write_enable = 1'b1;
        tick();
        check_both("nzp_write", 8'd0, 3'b010);

        // Branch taken; write enable in EXECUTE must not touch nzp
        core_state = 3'b101; pc_out_mux = 1'b1; nzp_instr = 3'b010;
        immediate = 8'd100; current_pc = 8'd10; nzp_out = 3'b100;
        tick();
        check_both("br_taken", 8'd100, 3'b010);

        nzp_instr = 3'b001;
        tick();
        check_both("br_not_taken", 8'd11, 3'b010);

        nzp_instr = 3'b000; current_pc = 8'd20;
        tick();
        check("br_mask000", next_pc, 8'd21);

        nzp_instr = 3'b111;
        tick();
        check("br_mask111", next_pc, 8'd100);

        pc_out_mux = 1'b0; current_pc = 8'd255;
        tick();
        check_both("seq_wrap", 8'd0, 3'b010);

        // enable low: everything holds
        enable = 1'b0; current_pc = 8'd50;
        tick();
        check_both("hold_exec", 8'd0, 3'b010);
        core_state = 3'b110; nzp_out = 3'b001;
        tick();
        check_both("hold_update", 8'd0, 3'b010);

        enable = 1'b1; nzp_write_enable = 1'b0;
        tick();
        check_both("update_no_we", 8'd0, 3'b010);

        nzp_write_enable = 1'b1; nzp_out = 3'b101;
        tick();
        check_both("update_non_onehot", 8'd0, 3'b101);

        core_state = 3'b101; pc_out_mux = 1'b1; nzp_instr = 3'b100;
        immediate = 8'd77; current_pc = 8'd3;
        tick();
        check("br_n_flag", next_pc, 8'd77);

        pc_out_mux = 1'b0; current_pc = 8'd40;
        tick();
        check("seq_flags_match", next_pc, 8'd41);

        // other core states hold both registers
        core_state = 3'b000; current_pc = 8'd9; nzp_out = 3'b010;
        tick();
        check_both("state_idle", 8'd41, 3'b101);
        core_state = 3'b111;
        tick();
        check_both("state_done", 8'd41, 3'b101);
        core_state = 3'b100;
        tick();
        check_both("state_wait", 8'd41, 3'b101);

        // reset dominates enable=0 and EXECUTE
        reset = 1'b1; enable = 1'b0; core_state = 3'b101;
        tick();
        check_both("reset_mid", 8'd0, 3'b000);
        reset = 1'b0; enable = 1'b1;
        pc_out_mux = 1'b1; nzp_instr = 3'b111; immediate = 8'd200; current_pc = 8'd5;
        tick();
        check_both("post_reset_exec", 8'd6, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
